// File: rtl/byte_striping_param.sv
// Round-robin byte striper: spreads WIDTH-bit words across LANES lanes, either
// one lane per cycle (MODE 0) or as complete, padded, backpressured stripes (MODE 1).
module byte_striping_param #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int MODE  = 0,
  parameter     PAD   = 8'hBC,
  localparam int PW   = $clog2(LANES)
) (
  input  logic                   clk_2f,
  input  logic                   reset,
  input  logic                   valid_in,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   last_in,
  input  logic                   ready_out,
  output logic                   in_ready,
  output logic [LANES*WIDTH-1:0] lane_data,
  output logic [LANES-1:0]       lane_valid,
  output logic                   stripe_last,
  output logic [PW-1:0]          lane_ptr,
  output logic                   drop_err
);

  localparam logic [WIDTH-1:0] PAD_W = WIDTH'(PAD);

  typedef enum logic {ASSEMBLE, STALL} state_t;

  state_t                 state_q, state_d;
  logic [LANES*WIDTH-1:0] asm_q;
  logic                   asm_last_q;
  logic [LANES*WIDTH-1:0] stripe;
  logic                   accept, complete, out_free, load_new, load_held;

  assign in_ready  = (MODE == 0) ? 1'b1 : (state_q == ASSEMBLE);
  assign accept    = valid_in & in_ready;
  assign complete  = accept & ((lane_ptr == PW'(LANES - 1)) | last_in);
  assign out_free  = (lane_valid == '0) | ready_out;
  assign load_new  = complete & out_free;
  assign load_held = (state_q == STALL) & ready_out;

  // Assembly view with the incoming word merged in and, on a frame end,
  // the unused upper slots padded.
  always_comb begin
    stripe = asm_q;
    for (int i = 0; i < LANES; i++) begin
      if (PW'(i) == lane_ptr)
        stripe[i*WIDTH +: WIDTH] = data_in;
      else if (last_in && (PW'(i) > lane_ptr))
        stripe[i*WIDTH +: WIDTH] = PAD_W;
    end
  end

  // NOTE: combinational blocks assign a default before any branch so that
  // no path leaves state_d unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    if (MODE != 0) begin
      case (state_q)
        ASSEMBLE: if (complete && !out_free) state_d = STALL;
        STALL:    if (ready_out)             state_d = ASSEMBLE;
        default:                             state_d = ASSEMBLE;
      endcase
    end
  end

  always_ff @(posedge clk_2f) begin
    if (!reset) state_q <= ASSEMBLE;
    else        state_q <= state_d;
  end

  // NOTE: the assembly register is reset together with the outputs so that a
  // reset in the middle of a stripe leaves no stale words behind.
  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      lane_data   <= '0;
      lane_valid  <= '0;
      stripe_last <= 1'b0;
      lane_ptr    <= '0;
      drop_err    <= 1'b0;
      asm_q       <= '0;
      asm_last_q  <= 1'b0;
    end else begin
      if (accept)
        lane_ptr <= last_in ? '0 : lane_ptr + PW'(1);
      if (valid_in && !in_ready)
        drop_err <= 1'b1;

      if (MODE == 0) begin
        if (accept) begin
          lane_data[lane_ptr*WIDTH +: WIDTH] <= data_in;
          lane_valid  <= LANES'(1) << lane_ptr;
          stripe_last <= last_in;
        end else begin
          lane_valid  <= '0;
          stripe_last <= 1'b0;
        end
      end else begin
        if (load_new) begin
          lane_data   <= stripe;
          lane_valid  <= '1;
          stripe_last <= last_in;
        end else if (load_held) begin
          lane_data   <= asm_q;
          lane_valid  <= '1;
          stripe_last <= asm_last_q;
        end else if (ready_out) begin
          lane_valid  <= '0;
          stripe_last <= 1'b0;
        end
        // A completed stripe that could not load stays here until STALL drains it.
        if (accept) begin
          asm_q      <= stripe;
          asm_last_q <= last_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_byte_striping_param.sv
// Bench for byte_striping_param: one immediate-mode and one aligned-mode instance
// share stimulus; directed scenarios plus random traffic against a queue-based model.
module tb_byte_striping_param;

  localparam int WIDTH = 8;
  localparam int LANES = 4;
  localparam int PW    = $clog2(LANES);
  localparam logic [WIDTH-1:0] PAD = 8'hBC;
  localparam int VW    = LANES*WIDTH + LANES + 1 + PW + 1 + 1;

  logic             clk_2f = 1'b0;
  logic             reset = 1'b0;
  logic             valid_in = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             last_in = 1'b0;
  logic             ready_out = 1'b0;

  logic                   d0_in_ready, d1_in_ready;
  logic [LANES*WIDTH-1:0] d0_lane_data, d1_lane_data;
  logic [LANES-1:0]       d0_lane_valid, d1_lane_valid;
  logic                   d0_stripe_last, d1_stripe_last;
  logic [PW-1:0]          d0_lane_ptr, d1_lane_ptr;
  logic                   d0_drop_err, d1_drop_err;

  int checks = 0;
  int errors = 0;

  always #5 clk_2f = ~clk_2f;

  byte_striping_param #(.WIDTH(WIDTH), .LANES(LANES), .MODE(0), .PAD(PAD)) dut0 (
    .clk_2f(clk_2f), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .last_in(last_in), .ready_out(ready_out), .in_ready(d0_in_ready),
    .lane_data(d0_lane_data), .lane_valid(d0_lane_valid), .stripe_last(d0_stripe_last),
    .lane_ptr(d0_lane_ptr), .drop_err(d0_drop_err));

  byte_striping_param #(.WIDTH(WIDTH), .LANES(LANES), .MODE(1), .PAD(PAD)) dut1 (
    .clk_2f(clk_2f), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .last_in(last_in), .ready_out(ready_out), .in_ready(d1_in_ready),
    .lane_data(d1_lane_data), .lane_valid(d1_lane_valid), .stripe_last(d1_stripe_last),
    .lane_ptr(d1_lane_ptr), .drop_err(d1_drop_err));

  // Reference model. Immediate mode: per-lane word store. Aligned mode: a queue
  // of words collected for the current frame stripe, one held stripe, one output.
  logic [WIDTH-1:0] m0_data [LANES];
  logic [LANES-1:0] m0_vld;
  logic             m0_last;
  int               m0_ptr;

  logic [WIDTH-1:0] m1_parts [$];
  logic [WIDTH-1:0] m1_hold [LANES];
  logic [WIDTH-1:0] m1_out  [LANES];
  bit               m1_held, m1_hold_last, m1_ov, m1_ol, m1_drop;

  task automatic model_step();
    logic [WIDTH-1:0] s [LANES];
    bit loaded;
    if (!reset) begin
      foreach (m0_data[i]) begin m0_data[i] = '0; m1_out[i] = '0; m1_hold[i] = '0; end
      m0_vld = '0; m0_last = 0; m0_ptr = 0;
      m1_parts.delete();
      m1_held = 0; m1_hold_last = 0; m1_ov = 0; m1_ol = 0; m1_drop = 0;
    end else begin
      if (valid_in) begin
        m0_data[m0_ptr] = data_in;
        m0_vld = '0;
        m0_vld[m0_ptr] = 1'b1;
        m0_last = last_in;
        m0_ptr = last_in ? 0 : (m0_ptr + 1) % LANES;
      end else begin
        m0_vld = '0;
        m0_last = 0;
      end

      loaded = 0;
      if (m1_held) begin
        if (valid_in) m1_drop = 1;
        if (ready_out) begin
          m1_out = m1_hold; m1_ov = 1; m1_ol = m1_hold_last; m1_held = 0; loaded = 1;
        end
      end else if (valid_in) begin
        m1_parts.push_back(data_in);
        if (m1_parts.size() == LANES || last_in) begin
          for (int i = 0; i < LANES; i++) s[i] = (i < m1_parts.size()) ? m1_parts[i] : PAD;
          m1_parts.delete();
          if (!m1_ov || ready_out) begin
            m1_out = s; m1_ov = 1; m1_ol = last_in; loaded = 1;
          end else begin
            m1_hold = s; m1_held = 1; m1_hold_last = last_in;
          end
        end
      end
      if (!loaded && ready_out) begin m1_ov = 0; m1_ol = 0; end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk_2f);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; valid_in = 1'b0; last_in = 1'b0;
    cycle();
    reset = 1'b1;
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic l);
    valid_in = 1'b1; data_in = d; last_in = l;
    cycle();
    valid_in = 1'b0; last_in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; valid_in = 1'b1; data_in = 8'h5A; ready_out = 1'b0;
    cycle(); cycle();
    checks++;
    if ({d0_lane_data, d0_lane_valid, d0_stripe_last, d0_lane_ptr, d0_drop_err} !== '0) begin
      errors++; $display("FAIL reset_mode0: outputs %h, expected 0",
        {d0_lane_data, d0_lane_valid, d0_stripe_last, d0_lane_ptr, d0_drop_err});
    end
    checks++;
    if ({d1_lane_data, d1_lane_valid, d1_stripe_last, d1_lane_ptr, d1_drop_err} !== '0) begin
      errors++; $display("FAIL reset_mode1: outputs %h, expected 0",
        {d1_lane_data, d1_lane_valid, d1_stripe_last, d1_lane_ptr, d1_drop_err});
    end
    valid_in = 1'b0;
    reset = 1'b1;
    checks++;
    if ({d0_in_ready, d1_in_ready} !== 2'b11) begin
      errors++; $display("FAIL reset_in_ready: got %b, expected 11", {d0_in_ready, d1_in_ready});
    end
  endtask

  task automatic test_mode0_distribution();
    logic [WIDTH-1:0] words [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [LANES-1:0] exp_v [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    ready_out = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(words[i], 1'b0);
      checks++;
      if (d0_lane_valid !== exp_v[i]) begin
        errors++; $display("FAIL m0_dist_valid[%0d]: got %b, expected %b", i, d0_lane_valid, exp_v[i]);
      end
    end
    checks++;
    if (d0_lane_data !== 32'h44332255) begin
      errors++; $display("FAIL m0_dist_data: got %h, expected 44332255", d0_lane_data);
    end
    checks++;
    if (d0_lane_ptr !== PW'(1)) begin
      errors++; $display("FAIL m0_dist_ptr: got %0d, expected 1", d0_lane_ptr);
    end
  endtask

  task automatic test_mode0_restart();
    logic [WIDTH-1:0] words [3] = '{8'hA1, 8'hA2, 8'hA3};
    logic             lasts [3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      send(words[i], lasts[i]);
      checks++;
      if (d0_stripe_last !== lasts[i]) begin
        errors++; $display("FAIL m0_restart_last[%0d]: got %b, expected %b", i, d0_stripe_last, lasts[i]);
      end
    end
    checks++;
    if (d0_lane_valid !== 4'b0001 || d0_lane_data[7:0] !== 8'hA3) begin
      errors++; $display("FAIL m0_restart_lane0: valid %b data %h, expected 0001 a3",
        d0_lane_valid, d0_lane_data[7:0]);
    end
  endtask

  task automatic test_mode1_full_stripe();
    logic [LANES-1:0]       ev;
    logic [LANES*WIDTH-1:0] ed;
    do_reset();
    ready_out = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(WIDTH'(i), 1'b0);
      ev = (i == 4 || i == 8) ? 4'b1111 : 4'b0000;
      checks++;
      if (d1_lane_valid !== ev) begin
        errors++; $display("FAIL m1_full_valid[%0d]: got %b, expected %b", i, d1_lane_valid, ev);
      end
      if (i == 4 || i == 8) begin
        ed = (i == 4) ? 32'h04030201 : 32'h08070605;
        checks++;
        if (d1_lane_data !== ed) begin
          errors++; $display("FAIL m1_full_data[%0d]: got %h, expected %h", i, d1_lane_data, ed);
        end
      end
    end
    cycle();
    checks++;
    if (d1_lane_valid !== 4'b0000) begin
      errors++; $display("FAIL m1_full_drain: got %b, expected 0000", d1_lane_valid);
    end
  endtask

  task automatic test_mode1_pad();
    do_reset();
    ready_out = 1'b1;
    send(8'h10, 1'b0);
    send(8'h20, 1'b1);
    checks++;
    if ({d1_lane_data, d1_lane_valid, d1_stripe_last, d1_lane_ptr} !== {32'hBCBC2010, 4'b1111, 1'b1, 2'd0}) begin
      errors++; $display("FAIL m1_pad: got data %h valid %b last %b ptr %0d, expected bcbc2010 1111 1 0",
        d1_lane_data, d1_lane_valid, d1_stripe_last, d1_lane_ptr);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ready_out = 1'b0;
    for (int i = 0; i < 8; i++) send(8'h21 + WIDTH'(i), 1'b0);
    checks++;
    if (d1_in_ready !== 1'b0 || d1_lane_data !== 32'h24232221) begin
      errors++; $display("FAIL bp_stall: in_ready %b data %h, expected 0 24232221", d1_in_ready, d1_lane_data);
    end
    send(8'hEE, 1'b0);
    checks++;
    if (d1_drop_err !== 1'b1 || d1_lane_ptr !== PW'(0)) begin
      errors++; $display("FAIL bp_drop: drop_err %b ptr %0d, expected 1 0", d1_drop_err, d1_lane_ptr);
    end
    ready_out = 1'b1;
    cycle();
    checks++;
    if (d1_lane_data !== 32'h28272625 || d1_lane_valid !== 4'b1111 || d1_in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_resume: data %h valid %b in_ready %b, expected 28272625 1111 1",
        d1_lane_data, d1_lane_valid, d1_in_ready);
    end
    cycle();
    checks++;
    if (d1_lane_valid !== 4'b0000 || d1_drop_err !== 1'b1) begin
      errors++; $display("FAIL bp_after: valid %b drop_err %b, expected 0000 1", d1_lane_valid, d1_drop_err);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ready_out = 1'b1;
    send(8'h41, 1'b0);
    send(8'h42, 1'b0);
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    checks++;
    if ({d1_lane_data, d1_lane_valid, d1_stripe_last, d1_lane_ptr, d1_drop_err} !== '0) begin
      errors++; $display("FAIL reset_mid_clear: outputs %h, expected 0",
        {d1_lane_data, d1_lane_valid, d1_stripe_last, d1_lane_ptr, d1_drop_err});
    end
    for (int i = 0; i < 4; i++) send(8'h31 + WIDTH'(i), 1'b0);
    checks++;
    if ({d1_lane_data, d1_lane_valid, d1_stripe_last} !== {32'h34333231, 4'b1111, 1'b0}) begin
      errors++; $display("FAIL reset_mid_stripe: data %h valid %b last %b, expected 34333231 1111 0",
        d1_lane_data, d1_lane_valid, d1_stripe_last);
    end
  endtask

  task automatic test_random();
    logic [VW-1:0]          act, exp;
    logic [LANES*WIDTH-1:0] pd;
    for (int n = 0; n < 1500; n++) begin
      reset     = ($urandom_range(99) != 0);
      valid_in  = ($urandom_range(99) < 70);
      data_in   = WIDTH'($urandom);
      last_in   = ($urandom_range(99) < 15);
      ready_out = ($urandom_range(99) < 60);
      cycle();

      foreach (m0_data[i]) pd[i*WIDTH +: WIDTH] = m0_data[i];
      exp = {pd, m0_vld, m0_last, PW'(m0_ptr), 1'b0, 1'b1};
      act = {d0_lane_data, d0_lane_valid, d0_stripe_last, d0_lane_ptr, d0_drop_err, d0_in_ready};
      checks++;
      if (act !== exp) begin
        errors++; $display("FAIL rand_mode0[%0d]: got %h, expected %h", n, act, exp);
      end

      foreach (m1_out[i]) pd[i*WIDTH +: WIDTH] = m1_out[i];
      exp = {pd, {LANES{m1_ov}}, m1_ol, PW'(m1_parts.size()), m1_drop, !m1_held};
      act = {d1_lane_data, d1_lane_valid, d1_stripe_last, d1_lane_ptr, d1_drop_err, d1_in_ready};
      checks++;
      if (act !== exp) begin
        errors++; $display("FAIL rand_mode1[%0d]: got %h, expected %h", n, act, exp);
      end
    end
    reset = 1'b1; valid_in = 1'b0; last_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mode0_distribution();
    test_mode0_restart();
    test_mode1_full_stripe();
    test_mode1_pad();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_striping_param.md
# byte_striping_param

Parametrised byte striper for the multi-lane PHY transmit path, running in the `clk_2f` domain between the parallel-to-lane stage and the per-lane serialisers. It distributes a stream of `WIDTH`-bit words round-robin across `LANES` lanes. It has two modes:
- **Immediate mode:** each word goes out on its own lane one cycle later, one lane valid at a time.
- **Aligned mode:** words are collected into a complete stripe, which is then presented on all lanes at once. This mode adds frame-end padding and downstream backpressure.

## Interface
- `WIDTH`, 8: bits per lane word.
- `LANES`, 4: lane count; power of two, 2..8. `PW = $clog2(LANES)`.
- `MODE`, 0: 0 = immediate, 1 = aligned.
- `PAD`, 8'hBC: fill word for unused lanes of a short final stripe (aligned mode); truncated or zero-extended to `WIDTH`.

Ports:
- `clk_2f`  in  1  clock. All logic is rising-edge.
- `reset`  in  1  synchronous, active-low reset.
- `valid_in`  in  1  `data_in` is valid this cycle.
- `data_in`  in  `WIDTH`  input word.
- `last_in`  in  1  the word is the final word of a frame. Qualified by `valid_in`.
- `ready_out`  in  1  downstream accepts the stripe. Aligned mode only; ignored in mode 0.
- `in_ready`  out  1  block can accept a word this cycle.
- `lane_data`  out  `LANES*WIDTH`  lane i occupies bits `[i*WIDTH +: WIDTH]`.
- `lane_valid`  out  `LANES`  per-lane valid.
- `stripe_last`  out  1  the current output carries the last word of a frame.
- `lane_ptr`  out  `PW`  lane that the next accepted word will occupy.
- `drop_err`  out  1  sticky flag: a word was presented while `in_ready = 0`.

## Operation
- **Reset** (`reset = 0` at an edge):
  - `lane_data`, `lane_valid`, `stripe_last`, `lane_ptr`, `drop_err` are cleared to 0.
  - The assembly register is cleared and the FSM goes to ASSEMBLE.
  - `in_ready` = 1 from the first cycle after reset deasserts.
  - Reset during a partial stripe or a stall discards all held data. No pad stripe is emitted.
- **Accept:** a word is accepted when `valid_in & in_ready`. `lane_ptr` increments mod `LANES` on each accept. It returns to 0 after an accepted word with `last_in = 1`, so every frame starts on lane 0.
- **Mode 0 (immediate):**
  - `in_ready` is tied to 1.
  - On an accept, the `lane_ptr` slice of `lane_data` is loaded and `lane_valid` = one-hot(`lane_ptr`). `stripe_last` = `last_in`.
  - The other lanes' data hold their previous values.
  - In a cycle with no accept, `lane_valid` = 0 and `stripe_last` = 0; data hold.
- **Mode 1 (aligned), FSM states ASSEMBLE and STALL:**
  - **ASSEMBLE:** `in_ready` = 1. Accepted words are written into assembly slot `lane_ptr`.
  - **Stripe completion:** a stripe completes on an accept with `lane_ptr = LANES-1`, or on an accept with `last_in = 1`.
  - **Padding:** on a `last_in` completion, slots above `lane_ptr` are filled with `PAD`.
  - **Output register is free** when `lane_valid == 0` or `ready_out = 1`. On completion:
    - If free, the completed stripe loads the output register at that same edge. `lane_valid` becomes all-ones and `stripe_last` = `last_in`.
    - If not free, the stripe is kept in the assembly register and the FSM goes to STALL.
  - **STALL:** `in_ready` = 0. On the first cycle with `ready_out = 1`, the stripe loads the output register and the FSM returns to ASSEMBLE.
  - **Output hold:** the output register holds its value while `lane_valid != 0` and `ready_out = 0`.
  - **Output drain:** when `ready_out = 1` and no new stripe loads, `lane_valid` and `stripe_last` clear to 0. `lane_data` holds.
- **Drops:** `valid_in = 1` while `in_ready = 0` drops the word. `drop_err` is set and stays set until reset. `lane_ptr` is unchanged.
- **Arithmetic:** `lane_ptr` is `PW` bits wide and wraps naturally, since `LANES` is a power of two.

## Timing
- **Mode 0:** word accepted at edge n appears on its lane after edge n (1-cycle latency). Full throughput, no stalls.
- **Mode 1:** the last word of a stripe, accepted at edge n, makes the stripe visible on all lanes after edge n.
  - With `ready_out` held at 1, throughput is one word per cycle and one stripe every `LANES` cycles.
  - A stall costs one cycle per cycle `ready_out` is low, plus zero cycles to resume: `in_ready` rises in the cycle after the load edge.
- **`last_in` on lane 0:** gives a stripe with one real word and `LANES-1` pad words.
- **Simultaneous events:** a completion in the same cycle that the output drains (`ready_out = 1`) is a back-to-back load; no bubble is inserted.

## Test plan
- **Mode 0 distribution:** `LANES = 4`, `WIDTH = 8`, `MODE = 0`. Send `0x11`, `0x22`, `0x33`, `0x44`, `0x55` on consecutive cycles.
  - Expect `lane_valid` = `0001`, `0010`, `0100`, `1000`, `0001` one cycle later each.
  - Expect lane 0 = `0x55` at the end and `lane_ptr` = 1.
- **Mode 0 frame restart:** send `0xA1`, then `0xA2` with `last_in = 1`, then `0xA3`.
  - Expect `0xA3` on lane 0 and `stripe_last` = 1 with `0xA2` only.
- **Mode 1 full stripe:** `MODE = 1`, `ready_out = 1`. Send `0x01` to `0x08` on consecutive cycles.
  - Expect `lane_data` = `{04,03,02,01}` one cycle after `0x04`, then `{08,07,06,05}` four cycles later.
  - Expect `lane_valid` = `1111` for exactly those two cycles.
- **Mode 1 pad:** send `0x10`, then `0x20` with `last_in = 1`.
  - Expect `lane_data` = `{BC,BC,20,10}`, `stripe_last` = 1, `lane_valid` = `1111`, `lane_ptr` = 0.
- **Backpressure:** with `ready_out = 0`, complete two stripes.
  - Expect `in_ready` = 0 after the second completion.
  - A `valid_in` pulse during the stall sets `drop_err` = 1.
  - Raising `ready_out` loads stripe 2 on the next edge, and `in_ready` = 1 the following cycle.
- **Reset mid-operation:** assert `reset = 0` after two words of a stripe, then resume.
  - Expect all outputs 0 and `lane_ptr` = 0.
  - The next four words form a clean stripe starting at lane 0.
